// File: rtl/checker_pkg.sv
// Shared types and helpers for the adder result checker.
package checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding expected sums; head is presented combinationally.
module sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign full  = (cnt_q == DEPTH[AW:0]);
    assign empty = (cnt_q == '0);
    assign level = cnt_q;

endmodule

// File: rtl/add_result_checker.sv
// Scoreboard for an a+b adder: queues expected sums, compares results, keeps stats.
module add_result_checker
    import checker_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     restart,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     res_valid,
    input  logic [WIDTH:0]           res,
    output logic                     mismatch,
    output logic [WIDTH:0]           exp_q,
    output logic [WIDTH:0]           got_q,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic                     underflow,
    output logic                     overflow,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   level
);

    state_e             state_q, state_d;
    logic               active;
    logic               do_pop;
    logic               do_push;
    logic               neq;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     head;
    logic               mismatch_q;
    logic [CNT_W-1:0]   pass_q, fail_q;
    logic               under_q, over_q, halted_q;

    assign sum = {1'b0, a} + {1'b0, b};

    // Emptiness/fullness are pre-cycle; a same-cycle pop frees a slot for a push when full.
    assign active  = (state_q != HALT) && !restart;
    assign do_pop  = active && res_valid && !fifo_empty;
    assign do_push = active && in_valid && (!fifo_full || do_pop);
    assign neq     = (head != res);

    sync_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clear (clear),
        .flush (restart),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (sum),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid || res_valid) state_d = RUN;
            RUN:     if (do_pop && neq && STOP_ON_FAIL) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        if (restart) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALT);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            mismatch_q <= 1'b0;
            exp_q      <= '0;
            got_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            under_q    <= 1'b0;
            over_q     <= 1'b0;
        end else if (restart) begin
            mismatch_q <= 1'b0;
            exp_q      <= '0;
            got_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            under_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            mismatch_q <= do_pop && neq;
            if (do_pop) begin
                exp_q <= head;
                got_q <= res;
                if (neq) fail_q <= sat_inc(fail_q);
                else     pass_q <= sat_inc(pass_q);
            end
            if (active && res_valid && fifo_empty)             under_q <= 1'b1;
            if (active && in_valid && fifo_full && !do_pop)    over_q  <= 1'b1;
        end
    end

    assign mismatch  = mismatch_q;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign underflow = under_q;
    assign overflow  = over_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_add_result_checker.sv
// Directed bench: stimulus queues expected compares, a monitor checks them as counters move.
module tb_add_result_checker;

    logic        clk = 1'b0;
    logic        clear, restart, in_valid, res_valid;
    logic [7:0]  a, b;
    logic [8:0]  res;
    logic        mismatch, underflow, overflow, halted;
    logic [8:0]  exp_q, got_q;
    logic [15:0] pass_cnt, fail_cnt;
    logic [2:0]  level;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [8:0] e;
        logic [8:0] g;
        logic       m;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;

    add_result_checker #(.WIDTH(8), .DEPTH(4), .STOP_ON_FAIL(1'b1)) dut (
        .clk       (clk),
        .clear     (clear),
        .restart   (restart),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res       (res),
        .mismatch  (mismatch),
        .exp_q     (exp_q),
        .got_q     (got_q),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .underflow (underflow),
        .overflow  (overflow),
        .halted    (halted),
        .level     (level)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", nm, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        res_valid = 1'b0;
        restart   = 1'b0;
        a = '0; b = '0; res = '0;
    endtask

    task automatic push_pair(input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        a = x;
        b = y;
    endtask

    // r is what the adder reports, e is the hand-computed correct sum.
    task automatic expect_cmp(input logic [8:0] r, input logic [8:0] e);
        sb_t s;
        res_valid = 1'b1;
        res = r;
        s.e = e;
        s.g = r;
        s.m = (e != r);
        sbq.push_back(s);
    endtask

    // Monitor: any counter step means a compare happened; check it against the queue head.
    logic [15:0] prev_p = '0, prev_f = '0;
    always @(negedge clk) begin
        sb_t s;
        if (clear) begin
            prev_p = '0;
            prev_f = '0;
        end else if (pass_cnt < prev_p || fail_cnt < prev_f) begin
            prev_p = pass_cnt;
            prev_f = fail_cnt;
        end else if (pass_cnt != prev_p || fail_cnt != prev_f) begin
            if (sbq.size() == 0) begin
                chk("unexpected_compare", sbq.size(), 1);
            end else begin
                s = sbq.pop_front();
                chk("mon_exp_q", exp_q, s.e);
                chk("mon_got_q", got_q, s.g);
                chk("mon_mismatch", mismatch, s.m);
                chk("mon_cnt_step", {pass_cnt - prev_p, fail_cnt - prev_f},
                    s.m ? {16'd0, 16'd1} : {16'd1, 16'd0});
            end
            prev_p = pass_cnt;
            prev_f = fail_cnt;
        end else begin
            chk("mon_no_cmp_mismatch", mismatch, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; restart = 1'b0; in_valid = 1'b0; res_valid = 1'b0;
        a = '0; b = '0; res = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_flags", {mismatch, underflow, overflow, halted}, 0);
        chk("rst_level", level, 0);
        clear = 1'b0;

        // Basic pass
        push_pair(8'd3, 8'd4); tick();
        chk("t1_level_push", level, 1);
        expect_cmp(9'd7, 9'd7); tick();
        chk("t1_pass", pass_cnt, 1);
        chk("t1_exp", exp_q, 9'd7);
        chk("t1_mis", mismatch, 0);
        chk("t1_level", level, 0);

        // Carry, mismatch, halt
        push_pair(8'hFF, 8'h01); tick();
        expect_cmp(9'h000, 9'h100); tick();
        chk("t2_mis", mismatch, 1);
        chk("t2_fail", fail_cnt, 1);
        chk("t2_exp", exp_q, 9'h100);
        chk("t2_got", got_q, 9'h000);
        chk("t2_halted", halted, 1);
        push_pair(8'd5, 8'd5); res_valid = 1'b1; res = 9'd10; tick();
        chk("t2_level_ignored", level, 0);
        chk("t2_mis_one_cycle", mismatch, 0);
        chk("t2_fail_hold", fail_cnt, 1);
        chk("t2_no_underflow", underflow, 0);
        chk("t2_still_halted", halted, 1);
        restart = 1'b1; tick();
        chk("t6_restart_halted", halted, 0);
        chk("t6_restart_cnts", {pass_cnt, fail_cnt}, 0);

        // Full with simultaneous push/pop, then overflow
        for (int i = 0; i < 4; i++) begin
            push_pair(i[7:0], 8'd10); tick();
        end
        chk("t3_full_level", level, 4);
        push_pair(8'd20, 8'd1); expect_cmp(9'd10, 9'd10); tick();
        chk("t3_pushpop_level", level, 4);
        chk("t3_pushpop_noovf", overflow, 0);
        push_pair(8'd1, 8'd1); tick();
        chk("t3_overflow", overflow, 1);
        chk("t3_ovf_level", level, 4);
        expect_cmp(9'd11, 9'd11); tick();
        expect_cmp(9'd12, 9'd12); tick();
        expect_cmp(9'd13, 9'd13); tick();
        expect_cmp(9'd21, 9'd21); tick();
        chk("t3_drain_level", level, 0);
        chk("t3_pass", pass_cnt, 5);
        chk("t3_no_underflow", underflow, 0);

        // Underflow with simultaneous push
        restart = 1'b1; tick();
        push_pair(8'd1, 8'd1); res_valid = 1'b1; res = 9'd2; tick();
        chk("t4_underflow", underflow, 1);
        chk("t4_cnts", {pass_cnt, fail_cnt}, 0);
        chk("t4_level", level, 1);
        expect_cmp(9'd2, 9'd2); tick();
        chk("t4_pass_after", pass_cnt, 1);

        // Pointer wrap
        restart = 1'b1; tick();
        for (int i = 0; i < 20; i++) begin
            push_pair(i[7:0], 8'(2 * i)); tick();
            expect_cmp(9'(3 * i), 9'(3 * i)); tick();
        end
        chk("t5_pass", pass_cnt, 20);
        chk("t5_level", level, 0);
        chk("t5_fail", fail_cnt, 0);
        chk("t5_flags", {underflow, overflow, halted}, 0);

        // Asynchronous clear mid-operation
        for (int i = 0; i < 3; i++) begin
            push_pair(8'd9, i[7:0]); tick();
        end
        chk("t6_level_pre", level, 3);
        #2 clear = 1'b1;
        #1;
        chk("t6_clr_level", level, 0);
        chk("t6_clr_cnts", {pass_cnt, fail_cnt}, 0);
        chk("t6_clr_vals", {exp_q, got_q}, 0);
        chk("t6_clr_flags", {mismatch, underflow, overflow, halted}, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        push_pair(8'd2, 8'd2); tick();
        expect_cmp(9'd4, 9'd4); tick();
        chk("t6_resume_pass", pass_cnt, 1);
        chk("t6_resume_level", level, 0);

        @(negedge clk);
        #1;
        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
